// File: rtl/drive_cmd_scheduler.sv
// drive_cmd_scheduler: turns drive command codes into ASCII bytes for a UART
// transmitter. Repeated commands are deduplicated into a small queue. The last
// byte is re-sent on an idle heartbeat, and a stop is forced when the command
// source goes quiet for too long.
//
// Handshake: a byte transfers on a clock edge where cmd_ready and uart_ready
// are both high. ascii_out is loaded on entry to PRESENT and is held stable
// until that transfer. cmd_ready is high only in PRESENT.
module drive_cmd_scheduler #(
    parameter int FIFO_DEPTH       = 4,
    parameter int HEARTBEAT_CYCLES = 12_500_000,
    parameter int WATCHDOG_CYCLES  = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2:0]                  command,
    input  logic                        valid,
    input  logic                        uart_ready,
    output logic [7:0]                  ascii_out,
    output logic                        cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        watchdog_stop
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES);
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_HOLD} state_t;

    // Command code to the ASCII letter the drive controller expects.
    function automatic logic [7:0] f_encode(input logic [2:0] code);
        logic [7:0] res;
        res = 8'h53;
        case (code)
            3'd0: res = 8'h53;
            3'd1: res = 8'h46;
            3'd2: res = 8'h42;
            3'd3: res = 8'h4C;
            3'd4: res = 8'h52;
            3'd5: res = 8'h50;
            3'd6: res = 8'h51;
            3'd7: res = 8'h58;
            default: res = 8'h53;
        endcase
        return res;
    endfunction

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [LW-1:0]     r_count;
    logic [2:0]        r_last_enq;
    logic [2:0]        r_last_sent;
    logic [7:0]        r_ascii;
    logic              r_overflow;
    logic              r_wd_stop;
    logic [HB_W-1:0]   r_hb;
    logic [WD_W-1:0]   r_wd;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_hb_fire;
    logic              w_load;
    logic [2:0]        w_load_code;
    logic              w_accept;
    logic              w_inject;
    logic              w_differs;
    logic              w_enq;
    logic              w_drop;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LW'(FIFO_DEPTH));
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    // The heartbeat only fires when the queue is empty, so queued work wins.
    assign w_hb_fire   = (r_state == ST_IDLE) && w_empty && (r_hb == HB_MAX);
    assign w_load      = w_pop || w_hb_fire;
    assign w_load_code = w_empty ? r_last_sent : r_mem[r_rd_ptr];
    assign w_accept    = (r_state == ST_PRESENT) && uart_ready;
    // A valid strobe in the expiry cycle cancels the stop.
    assign w_inject    = !valid && (r_wd == WD_MAX) && (r_last_enq != 3'd0);
    assign w_differs   = valid && (command != r_last_enq);
    assign w_enq       = w_differs && (!w_full || w_pop);
    assign w_drop      = w_differs && w_full && !w_pop;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_load)      w_state_next = ST_PRESENT;
            ST_PRESENT: if (uart_ready)  w_state_next = ST_HOLD;
            ST_HOLD:    if (!uart_ready) w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    // FSM and status outputs.
    always_comb begin
        cmd_ready     = (r_state == ST_PRESENT);
        ascii_out     = r_ascii;
        fifo_level    = r_count;
        overflow      = r_overflow;
        watchdog_stop = r_wd_stop;
    end

    // Queue storage; a watchdog stop writes code 0 at the write pointer.
    always_ff @(posedge clk) begin
        if (w_inject)   r_mem[r_wr_ptr] <= 3'd0;
        else if (w_enq) r_mem[r_wr_ptr] <= command;
    end

    // Queue pointers and occupancy; a watchdog stop leaves only the injected stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_inject) begin
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= LW'(1);
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_enq && !w_pop)      r_count <= r_count + LW'(1);
            else if (!w_enq && w_pop) r_count <= r_count - LW'(1);
        end
    end

    // Dedup reference, sticky overflow and the forced-stop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_enq <= 3'd0;
            r_overflow <= 1'b0;
            r_wd_stop  <= 1'b0;
        end else begin
            if (w_inject)   r_last_enq <= 3'd0;
            else if (w_enq) r_last_enq <= command;
            if (w_drop) r_overflow <= 1'b1;
            if (valid)         r_wd_stop <= 1'b0;
            else if (w_inject) r_wd_stop <= 1'b1;
        end
    end

    // Output byte; it is loaded only on entry to PRESENT and is remembered for the heartbeat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ascii     <= 8'h00;
            r_last_sent <= 3'd0;
        end else if (w_load) begin
            r_ascii     <= f_encode(w_load_code);
            r_last_sent <= w_load_code;
        end
    end

    // Heartbeat counter: cleared by each accepted byte, and advances while idle with an empty queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                                r_hb <= '0;
        else if (w_accept)                                           r_hb <= '0;
        else if ((r_state == ST_IDLE) && w_empty && (r_hb != HB_MAX)) r_hb <= r_hb + HB_W'(1);
    end

    // Watchdog counter: cleared by any valid strobe, and saturates at expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_wd <= '0;
        else if (valid)          r_wd <= '0;
        else if (r_wd != WD_MAX) r_wd <= r_wd + WD_W'(1);
    end

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler. A queue-based reference model is
// compared with the outputs on every cycle. Hand-computed literals pin the
// latencies, the byte sequences and the reset behaviour.
module tb_drive_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int HB    = 20;
    localparam int WD    = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] command = 3'd0;
    logic       valid = 1'b0;
    logic       uart_ready = 1'b1;
    logic [7:0] ascii_out;
    logic       cmd_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       watchdog_stop;

    drive_cmd_scheduler #(
        .FIFO_DEPTH(DEPTH), .HEARTBEAT_CYCLES(HB), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .command(command), .valid(valid),
        .uart_ready(uart_ready), .ascii_out(ascii_out), .cmd_ready(cmd_ready),
        .fifo_level(fifo_level), .overflow(overflow), .watchdog_stop(watchdog_stop)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] enc_tab [8] = '{8'h53, 8'h46, 8'h42, 8'h4C, 8'h52, 8'h50, 8'h51, 8'h58};

    // Reference model. Transfer phase: 0 idle, 1 byte offered, 2 waiting for the uart to start.
    int         m_q[$];
    int         m_last_enq = 0;
    int         m_last_sent = 0;
    int         m_phase = 0;
    int         m_hb = 0;
    int         m_wd = 0;
    bit         m_ovf = 0;
    bit         m_stop = 0;
    logic [7:0] m_shown = 8'h00;

    task automatic m_reset();
        m_q.delete();
        m_last_enq = 0; m_last_sent = 0; m_phase = 0;
        m_hb = 0; m_wd = 0; m_ovf = 0; m_stop = 0; m_shown = 8'h00;
    endtask

    task automatic m_step();
        int  old_phase;
        bit  old_empty;
        bit  accept;
        bit  start_q;
        bit  start_hb;
        bit  inject;
        int  code;
        old_phase = m_phase;
        old_empty = (m_q.size() == 0);
        accept    = (old_phase == 1) && uart_ready;
        start_q   = (old_phase == 0) && !old_empty;
        start_hb  = (old_phase == 0) && old_empty && (m_hb == HB - 1);
        inject    = !valid && (m_wd == WD - 1) && (m_last_enq != 0);
        if (start_q || start_hb)              m_phase = 1;
        else if (old_phase == 1 && uart_ready)  m_phase = 2;
        else if (old_phase == 2 && !uart_ready) m_phase = 0;
        code = m_last_sent;
        if (start_q) code = m_q.pop_front();
        if (start_q || start_hb) begin
            m_shown = enc_tab[code];
            m_last_sent = code;
        end
        if (inject) begin
            m_q.delete();
            m_q.push_back(0);
            m_last_enq = 0;
            m_stop = 1;
        end else if (valid && int'(command) != m_last_enq) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(int'(command));
                m_last_enq = int'(command);
            end else begin
                m_ovf = 1;
            end
        end
        if (valid) m_stop = 0;
        if (accept) m_hb = 0;
        else if (old_phase == 0 && old_empty && m_hb < HB - 1) m_hb++;
        if (valid) m_wd = 0;
        else if (m_wd < WD - 1) m_wd++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else          m_step();
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("m_cmd_ready", cmd_ready, m_phase == 1);
        check("m_ascii_out", ascii_out, m_shown);
        check("m_fifo_level", fifo_level, m_q.size());
        check("m_overflow", overflow, m_ovf);
        check("m_watchdog_stop", watchdog_stop, m_stop);
    end

    // UART model (busy for 10 cycles after each accept) and the byte scoreboard.
    logic [7:0] exp_q[$];
    bit         armed = 0;
    bit         uart_block = 0;
    bit         acc = 0;
    int         busy = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         acc_cyc[$];

    always begin
        @(negedge clk);
        acc = cmd_ready && uart_ready;
        if (acc) begin
            n_acc++;
            acc_cyc.push_back(cyc);
            if (armed) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got byte 0x%02h, expected no byte (t=%0t)", ascii_out, $time);
                end else begin
                    check("sb_byte", ascii_out, exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        cyc++;
        #2;
        if (acc) busy = 10;
        else if (busy > 0) busy--;
        uart_ready = (busy == 0) && !uart_block;
    end

    // Driver tasks.
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        @(posedge clk); #1;
        valid = 1'b1;
        command = c;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_bytes(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    int n;
    int acc_snap;

    initial begin
        #1 reset_n = 1'b0;
        #10;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_ascii", ascii_out, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_wd_stop", watchdog_stop, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Single command: the byte is offered two cycles after the strobe.
        do_reset();
        armed = 1; exp_q.push_back(8'h46);
        send_cmd(3'd1);
        check("a_level_enq", fifo_level, 1);
        check("a_rdy_early", cmd_ready, 0);
        @(posedge clk); #1;
        check("a_rdy_2cyc", cmd_ready, 1);
        check("a_ascii", ascii_out, 8'h46);
        check("a_level_popped", fifo_level, 0);
        wait_bytes(40, "a_bytes");
        armed = 0;

        // Dedup: 3,3,3,4 sends L then R.
        do_reset();
        armed = 1; exp_q.push_back(8'h4C); exp_q.push_back(8'h52);
        send_cmd(3'd3); send_cmd(3'd3); send_cmd(3'd3); send_cmd(3'd4);
        wait_bytes(80, "b_bytes");
        armed = 0;

        // Overflow: P is held in PRESENT, F B L R fill the queue, and the last two commands are dropped.
        do_reset();
        uart_block = 1;
        armed = 1;
        exp_q.push_back(8'h50); exp_q.push_back(8'h46); exp_q.push_back(8'h42);
        exp_q.push_back(8'h4C); exp_q.push_back(8'h52);
        send_cmd(3'd5); send_cmd(3'd1); send_cmd(3'd2); send_cmd(3'd3);
        send_cmd(3'd4); send_cmd(3'd1); send_cmd(3'd2);
        check("c_level_full", fifo_level, 4);
        check("c_overflow", overflow, 1);
        check("c_ascii_held", ascii_out, 8'h50);
        uart_block = 0;
        wait_bytes(200, "c_bytes");
        check("c_overflow_sticky", overflow, 1);
        check("c_level_drained", fifo_level, 0);
        armed = 0;

        // Heartbeat: F, then re-sent every 20 idle cycles plus 2 transfer cycles.
        do_reset();
        armed = 1;
        exp_q.push_back(8'h46); exp_q.push_back(8'h46); exp_q.push_back(8'h46);
        acc_cyc.delete();
        send_cmd(3'd1);
        wait_bytes(150, "d_bytes");
        check("d_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() >= 3) begin
            check("d_interval1", acc_cyc[1] - acc_cyc[0], 22);
            check("d_interval2", acc_cyc[2] - acc_cyc[1], 22);
        end
        armed = 0;

        // Watchdog: 100 quiet cycles after B force an S; the next B clears the stop.
        do_reset();
        send_cmd(3'd2);
        n = 0;
        while (!watchdog_stop && n < 150) begin
            @(posedge clk); #1;
            n++;
        end
        check("e_wd_latency", n, 100);
        check("e_level_inject", fifo_level, 1);
        armed = 1; exp_q.push_back(8'h53);
        wait_bytes(40, "e_stop_byte");
        check("e_stop_held", watchdog_stop, 1);
        exp_q.push_back(8'h42);
        send_cmd(3'd2);
        check("e_stop_cleared", watchdog_stop, 0);
        wait_bytes(60, "e_resume_byte");
        armed = 0;

        // A valid strobe in the expiry cycle cancels the stop.
        do_reset();
        send_cmd(3'd2);
        repeat (98) @(posedge clk);
        send_cmd(3'd2);
        check("e2_no_stop", watchdog_stop, 0);
        check("e2_no_inject", fifo_level, 0);
        repeat (5) @(posedge clk); #1;
        check("e2_still_no_stop", watchdog_stop, 0);

        // Reset while R is offered: outputs drop at once, and the first heartbeat after release is S, 20 cycles later.
        do_reset();
        uart_block = 1;
        send_cmd(3'd4);
        @(posedge clk); #1;
        check("f_rdy", cmd_ready, 1);
        check("f_ascii", ascii_out, 8'h52);
        acc_snap = n_acc;
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("f_rst_rdy", cmd_ready, 0);
        check("f_rst_ascii", ascii_out, 8'h00);
        check("f_rst_level", fifo_level, 0);
        check("f_rst_ovf", overflow, 0);
        check("f_rst_stop", watchdog_stop, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        uart_block = 0;
        armed = 1; exp_q.push_back(8'h53);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("f_hb_first", n, 20);
        check("f_hb_ascii", ascii_out, 8'h53);
        check("f_no_accept", n_acc - acc_snap, 0);
        wait_bytes(40, "f_bytes");
        armed = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Time bound for the whole run.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
